host_word_bridge: RTL

Converts the CPU's 32-bit word memory ops into single-cache-line (512-bit) DMA transfers and back. Sits between the CPU's `op`/`io_address`/`common_data_bus` port and the `dma_if` peripheral signals in the AFU, after address translation. It is the unit that drives `ready`, `tx_done` and `rd_valid` to the CPU. It keeps a one-line write-through buffer so that repeated word accesses to the same line skip the DMA.

---
 rtl/host_bridge_pkg.sv | 26 ++
 rtl/host_word_bridge_if.sv | 43 ++++
 rtl/host_word_bridge_line_word_sel.sv | 25 ++
 rtl/host_word_bridge.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/host_bridge_pkg.sv
// rtl/host_bridge_pkg.sv - shared op/state types and line geometry for host_word_bridge
package host_bridge_pkg;

  localparam int WORDS_PER_LINE   = 16;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int WORD_OFFSET_BITS = 2;
  localparam int WORD_IDX_BITS    = LINE_OFFSET_BITS - WORD_OFFSET_BITS;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_GO,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WR_GO,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/host_word_bridge_if.sv
// rtl/host_word_bridge_if.sv - CPU word port and DMA line port seen by host_word_bridge
interface host_word_bridge_if #(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
);
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] io_address;
  logic [WORD_WIDTH-1:0] cpu_wr_data;
  logic                  flush;
  logic [WORD_WIDTH-1:0] cpu_rd_data;
  logic                  rd_valid;
  logic                  tx_done;
  logic                  ready;
  logic                  dma_rd_go;
  logic                  dma_rd_en;
  logic [ADDR_WIDTH-1:0] dma_rd_addr;
  logic [LINE_WIDTH-1:0] dma_rd_data;
  logic                  dma_empty;
  logic                  dma_wr_go;
  logic                  dma_wr_en;
  logic [ADDR_WIDTH-1:0] dma_wr_addr;
  logic [LINE_WIDTH-1:0] dma_wr_data;
  logic                  dma_full;
  logic                  dma_wr_done;

  // The bridge is the slave of the CPU side and drives the DMA side.
  modport slave (
    input  op, io_address, cpu_wr_data, flush,
    input  dma_rd_data, dma_empty, dma_full, dma_wr_done,
    output cpu_rd_data, rd_valid, tx_done, ready,
    output dma_rd_go, dma_rd_en, dma_rd_addr,
    output dma_wr_go, dma_wr_en, dma_wr_addr, dma_wr_data
  );

  modport master (
    output op, io_address, cpu_wr_data, flush,
    output dma_rd_data, dma_empty, dma_full, dma_wr_done,
    input  cpu_rd_data, rd_valid, tx_done, ready,
    input  dma_rd_go, dma_rd_en, dma_rd_addr,
    input  dma_wr_go, dma_wr_en, dma_wr_addr, dma_wr_data
  );
endinterface

// File: rtl/host_word_bridge_line_word_sel.sv
// rtl/host_word_bridge_line_word_sel.sv - word extract and single-word replace on a cache line
module line_word_sel #(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [LINE_WIDTH-1:0] line_o
);
  localparam int WORDS = LINE_WIDTH / WORD_WIDTH;

  always_comb begin
    word_o = '0;
    line_o = line_i;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_i == IDX_WIDTH'(i)) begin
        word_o                              = line_i[i*WORD_WIDTH +: WORD_WIDTH];
        line_o[i*WORD_WIDTH +: WORD_WIDTH]  = word_i;
      end
    end
  end
endmodule

// File: rtl/host_word_bridge.sv
// rtl/host_word_bridge.sv - CPU word ops to single-line DMA transfers with a one-line write-through buffer
module host_word_bridge
  import host_bridge_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  host_word_bridge_if.slave     bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - LINE_OFFSET_BITS;

  state_e                              state_q, state_d;
  logic                                is_wr_q;
  logic [ADDR_WIDTH-1:WORD_OFFSET_BITS] addr_q;
  logic [WORD_WIDTH-1:0]               wdata_q;
  logic [WORD_WIDTH-1:0]               rd_hold_q;
  logic                                valid_q;
  logic [TAG_WIDTH-1:0]                tag_q;
  logic [LINE_WIDTH-1:0]               line_q;
  logic [ADDR_WIDTH-1:0]               rd_addr_q;
  logic [ADDR_WIDTH-1:0]               wr_addr_q;
  logic                                pushed_q;

  op_e                                 op_in;
  logic [TAG_WIDTH-1:0]                in_tag;
  logic [TAG_WIDTH-1:0]                req_tag;
  logic [WORD_IDX_BITS-1:0]            req_idx;
  logic                                accept;
  logic                                hit;
  logic                                pop;
  logic                                push;
  logic                                done_rd;
  logic [WORD_WIDTH-1:0]               sel_word;
  logic [LINE_WIDTH-1:0]               merged_line;

  assign op_in   = op_e'(bus.op);
  assign in_tag  = bus.io_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
  assign req_tag = addr_q[ADDR_WIDTH-1:LINE_OFFSET_BITS];
  assign req_idx = addr_q[LINE_OFFSET_BITS-1:WORD_OFFSET_BITS];
  assign accept  = (state_q == ST_IDLE) && ((op_in == OP_RD) || (op_in == OP_WR));
  // A flush in the acceptance cycle takes effect first, forcing a miss.
  assign hit     = valid_q && !bus.flush && (tag_q == in_tag);
  assign pop     = (state_q == ST_RD_WAIT) && !bus.dma_empty;
  assign push    = (state_q == ST_WR_WAIT) && !pushed_q && !bus.dma_full;
  assign done_rd = (state_q == ST_DONE) && !is_wr_q;

  line_word_sel #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (WORD_IDX_BITS)
  ) u_sel (
    .line_i (line_q),
    .idx_i  (req_idx),
    .word_i (wdata_q),
    .word_o (sel_word),
    .line_o (merged_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!hit)                 state_d = ST_RD_GO;
          else if (op_in == OP_WR)  state_d = ST_MERGE;
          else                      state_d = ST_DONE;
        end
      end
      ST_RD_GO:   state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (pop) state_d = is_wr_q ? ST_MERGE : ST_DONE;
      ST_MERGE:   state_d = ST_WR_GO;
      ST_WR_GO:   state_d = ST_WR_WAIT;
      // Completion is only honoured once this transfer's line has been pushed.
      ST_WR_WAIT: if (pushed_q && bus.dma_wr_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready       = (state_q == ST_IDLE);
    bus.dma_rd_go   = (state_q == ST_RD_GO);
    bus.dma_rd_en   = pop;
    bus.dma_wr_go   = (state_q == ST_WR_GO);
    bus.dma_wr_en   = push;
    bus.tx_done     = (state_q == ST_DONE);
    bus.rd_valid    = done_rd;
    bus.cpu_rd_data = done_rd ? sel_word : rd_hold_q;
    bus.dma_rd_addr = rd_addr_q;
    bus.dma_wr_addr = wr_addr_q;
    bus.dma_wr_data = line_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_hold_q <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      line_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      pushed_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (bus.flush) valid_q <= 1'b0;
        if (accept) begin
          is_wr_q <= (op_in == OP_WR);
          addr_q  <= bus.io_address[ADDR_WIDTH-1:WORD_OFFSET_BITS];
          wdata_q <= bus.cpu_wr_data;
          if (!hit) rd_addr_q <= {in_tag, {LINE_OFFSET_BITS{1'b0}}};
        end
      end
      if (pop) begin
        line_q  <= bus.dma_rd_data;
        valid_q <= 1'b1;
        tag_q   <= req_tag;
      end
      if (state_q == ST_MERGE) begin
        line_q    <= merged_line;
        wr_addr_q <= {req_tag, {LINE_OFFSET_BITS{1'b0}}};
      end
      if (state_q == ST_WR_GO) pushed_q <= 1'b0;
      if (push)                pushed_q <= 1'b1;
      if (done_rd)             rd_hold_q <= sel_word;
    end
  end

endmodule
